// File: rtl/mem_arbiter_if.sv
// Bundle of requester, response and shared-memory-port signals around mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;

    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        stallreq;

    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               bus_ack, bus_rdata,
        output if_ack, if_rdata, if_err, mem_ack, mem_rdata, mem_err,
               bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq
    );

    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
               bus_ack, bus_rdata,
        input  if_ack, if_rdata, if_err, mem_ack, mem_rdata, mem_err,
               bus_req, bus_we, bus_sel, bus_addr, bus_wdata, stallreq
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (data over fetch) arbiter sharing one memory port between two requesters.
// Define ARB_TIMEOUT_EN to abort transactions that see no bus_ack within TIMEOUT_CYC cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  io
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 15) begin : g_bad_timeout
        $error("mem_arbiter: TIMEOUT_CYC must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, GNT_MEM, GNT_IF} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        if_ack_q, if_ack_d;
    logic        mem_ack_q, mem_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_err_q, if_err_d;
    logic        mem_err_q, mem_err_d;
    logic        if_go, mem_go;
    logic        timeout;

    // A requester whose ack is showing cannot be granted again in that same cycle.
    assign if_go  = io.if_req  & ~if_ack_q;
    assign mem_go = io.mem_req & ~mem_ack_q;

`ifdef ARB_TIMEOUT_EN
    logic [3:0] cnt_q, cnt_d;
    assign timeout = (state_q != IDLE) && !io.bus_ack && (cnt_q == 4'(TIMEOUT_CYC - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            sel_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_err_q    <= 1'b0;
            mem_err_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_err_q    <= if_err_d;
            mem_err_q   <= mem_err_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_go)     state_d = GNT_MEM;
                else if (if_go) state_d = GNT_IF;
            end
            GNT_MEM, GNT_IF: begin
                if (io.bus_ack || timeout) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d        = we_q;
        sel_d       = sel_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_err_d    = 1'b0;
        mem_err_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = '0;
        if (state_q != IDLE && !io.bus_ack) cnt_d = cnt_q + 4'd1;
`endif
        case (state_q)
            IDLE: begin
                if (state_d == GNT_MEM) begin
                    we_d    = io.mem_we;
                    sel_d   = io.mem_sel;
                    addr_d  = io.mem_addr;
                    wdata_d = io.mem_wdata;
                end else if (state_d == GNT_IF) begin
                    we_d    = 1'b0;
                    sel_d   = 4'b1111;
                    addr_d  = io.if_addr;
                    wdata_d = '0;
                end
            end
            GNT_MEM: begin
                if (io.bus_ack) begin
                    mem_ack_d = 1'b1;
                    if (!we_q) mem_rdata_d = io.bus_rdata;
                end else if (timeout) begin
                    mem_ack_d   = 1'b1;
                    mem_err_d   = 1'b1;
                    mem_rdata_d = '0;
                end
            end
            GNT_IF: begin
                if (io.bus_ack) begin
                    if_ack_d   = 1'b1;
                    if_rdata_d = io.bus_rdata;
                end else if (timeout) begin
                    if_ack_d   = 1'b1;
                    if_err_d   = 1'b1;
                    if_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    assign io.bus_req   = (state_q != IDLE);
    assign io.bus_we    = (state_q != IDLE) & we_q;
    assign io.bus_sel   = sel_q;
    assign io.bus_addr  = addr_q;
    assign io.bus_wdata = wdata_q;
    assign io.if_ack    = if_ack_q;
    assign io.mem_ack   = mem_ack_q;
    assign io.if_rdata  = if_rdata_q;
    assign io.mem_rdata = mem_rdata_q;
    assign io.if_err    = if_err_q;
    assign io.mem_err   = mem_err_q;
    assign io.stallreq  = (io.if_req & ~if_ack_q) | (io.mem_req & ~mem_ack_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, collision, wait states, timeout, mid-op reset.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    mem_arbiter_if io();

    mem_arbiter #(.TIMEOUT_CYC(15)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b0;
        io.if_req = 1'b1;  io.if_addr = 32'h100;
        io.mem_req = 1'b0; io.mem_we = 1'b0; io.mem_sel = 4'h0;
        io.mem_addr = '0;  io.mem_wdata = '0;
        io.bus_ack = 1'b0; io.bus_rdata = '0;

        // reset held two cycles with a fetch pending
        step(); step();
        chk("rst_bus_req",   io.bus_req,   0);
        chk("rst_bus_we",    io.bus_we,    0);
        chk("rst_bus_addr",  io.bus_addr,  0);
        chk("rst_if_ack",    io.if_ack,    0);
        chk("rst_mem_ack",   io.mem_ack,   0);
        chk("rst_if_rdata",  io.if_rdata,  0);
        chk("rst_mem_rdata", io.mem_rdata, 0);
        chk("rst_if_err",    io.if_err,    0);
        chk("rst_stall",     io.stallreq,  1);

        // single read
        rst = 1'b1;
        step();
        chk("rd_bus_req",  io.bus_req,  1);
        chk("rd_bus_addr", io.bus_addr, 32'h100);
        chk("rd_bus_sel",  io.bus_sel,  4'hF);
        chk("rd_bus_we",   io.bus_we,   0);
        chk("rd_if_ack0",  io.if_ack,   0);
        io.bus_ack = 1'b1; io.bus_rdata = 32'h34011234;
        step();
        chk("rd_if_ack",   io.if_ack,   1);
        chk("rd_if_rdata", io.if_rdata, 32'h34011234);
        chk("rd_if_err",   io.if_err,   0);
        chk("rd_bus_idle", io.bus_req,  0);
        chk("rd_stall",    io.stallreq, 0);
        io.if_req = 1'b0; io.bus_ack = 1'b0; io.bus_rdata = 32'hFFFF0000;
        step();
        chk("rd_if_ack_end",   io.if_ack,   0);
        chk("rd_if_rdata_hold", io.if_rdata, 32'h34011234);

        // collision: store wins, then fetch after one idle cycle
        io.if_req = 1'b1; io.if_addr = 32'h300;
        io.mem_req = 1'b1; io.mem_we = 1'b1; io.mem_sel = 4'b0011;
        io.mem_addr = 32'h200; io.mem_wdata = 32'hDEADBEEF;
        #1;
        chk("col_stall0", io.stallreq, 1);
        step();
        chk("col_st_req",   io.bus_req,   1);
        chk("col_st_we",    io.bus_we,    1);
        chk("col_st_sel",   io.bus_sel,   4'b0011);
        chk("col_st_addr",  io.bus_addr,  32'h200);
        chk("col_st_wdata", io.bus_wdata, 32'hDEADBEEF);
        chk("col_stall1",   io.stallreq,  1);
        io.bus_ack = 1'b1; io.bus_rdata = 32'hAAAA5555;
        step();
        chk("col_mem_ack",   io.mem_ack,   1);
        chk("col_wr_rdata",  io.mem_rdata, 0);
        chk("col_idle",      io.bus_req,   0);
        chk("col_stall2",    io.stallreq,  1);
        io.bus_ack = 1'b0;
        step();
        chk("col_if_req",   io.bus_req,  1);
        chk("col_if_we",    io.bus_we,   0);
        chk("col_if_addr",  io.bus_addr, 32'h300);
        chk("col_mem_ack0", io.mem_ack,  0);
        chk("col_stall3",   io.stallreq, 1);
        io.mem_req = 1'b0;
        io.bus_ack = 1'b1; io.bus_rdata = 32'h0BADF00D;
        step();
        chk("col_if_ack",   io.if_ack,   1);
        chk("col_if_rdata", io.if_rdata, 32'h0BADF00D);
        chk("col_stall4",   io.stallreq, 0);
        io.if_req = 1'b0; io.bus_ack = 1'b0;
        step();
        chk("col_end_idle", io.bus_req, 0);

        // wait states, requester drops req while waiting
        io.mem_req = 1'b1; io.mem_we = 1'b0; io.mem_sel = 4'hF; io.mem_addr = 32'h440;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("ws_bus_req",  io.bus_req,  1);
            chk("ws_bus_addr", io.bus_addr, 32'h440);
            chk("ws_bus_sel",  io.bus_sel,  4'hF);
            chk("ws_mem_ack0", io.mem_ack,  0);
            if (i == 1) io.mem_req = 1'b0;
            step();
        end
        io.bus_ack = 1'b1; io.bus_rdata = 32'h5A5A0001;
        step();
        chk("ws_mem_ack",   io.mem_ack,   1);
        chk("ws_mem_err",   io.mem_err,   0);
        chk("ws_mem_rdata", io.mem_rdata, 32'h5A5A0001);
        io.bus_ack = 1'b0;
        step();
        chk("ws_mem_ack_end", io.mem_ack, 0);
        chk("ws_idle",        io.bus_req, 0);

        // no bus_ack ever
        io.if_req = 1'b1; io.if_addr = 32'h500;
        step();
        for (int i = 0; i < 15; i++) begin
            chk("to_bus_req", io.bus_req, 1);
            chk("to_if_ack0", io.if_ack,  0);
            step();
        end
`ifdef ARB_TIMEOUT_EN
        chk("to_bus_drop", io.bus_req,  0);
        chk("to_if_ack",   io.if_ack,   1);
        chk("to_if_err",   io.if_err,   1);
        chk("to_if_rdata", io.if_rdata, 0);
        io.if_req = 1'b0;
        step();
        chk("to_if_ack_end", io.if_ack, 0);
        chk("to_if_err_end", io.if_err, 0);
`else
        chk("to_bus_hold", io.bus_req, 1);
        chk("to_if_ack",   io.if_ack,  0);
        chk("to_if_err",   io.if_err,  0);
        io.bus_ack = 1'b1; io.bus_rdata = 32'h00000077;
        step();
        chk("to_late_ack",   io.if_ack,   1);
        chk("to_late_rdata", io.if_rdata, 32'h00000077);
        chk("to_late_err",   io.if_err,   0);
        io.if_req = 1'b0; io.bus_ack = 1'b0;
        step();
`endif

        // reset in the second GNT_MEM cycle, then a stray ack
        io.mem_req = 1'b1; io.mem_we = 1'b0; io.mem_addr = 32'h600; io.mem_sel = 4'hC;
        step();
        chk("mr_gnt", io.bus_req, 1);
        step();
        rst = 1'b0;
        step();
        chk("mr_bus_req",   io.bus_req,   0);
        chk("mr_mem_ack",   io.mem_ack,   0);
        chk("mr_mem_rdata", io.mem_rdata, 0);
        chk("mr_bus_sel",   io.bus_sel,   0);
        chk("mr_if_rdata",  io.if_rdata,  0);
        rst = 1'b1; io.mem_req = 1'b0; io.bus_ack = 1'b1; io.bus_rdata = 32'h12345678;
        step();
        chk("mr_no_ack",  io.mem_ack,   0);
        chk("mr_idle",    io.bus_req,   0);
        chk("mr_rdata",   io.mem_rdata, 0);
        io.bus_ack = 1'b0;
        step();
        chk("mr_no_ack2", io.mem_ack, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
